// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode map, instruction field positions and
// fetch state encoding, used by fetch and decode.
`default_nettype none

package proc_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 8;

  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [3:0] get_opcode(input logic [15:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] get_target(input logic [15:0] inst);
    return inst[TGT_MSB:TGT_LSB];
  endfunction

  function automatic logic is_jmp(input logic [15:0] inst);
    return get_opcode(inst) == OP_JMP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc.sv
// Program counter register: load has priority over increment, otherwise hold.
// Increment wraps modulo 2^ADDR_W.
`default_nettype none

module fetch_pc #(
  parameter int          ADDR_W   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM address from the PC, folds jmp
// locally, honours branch redirects and presents instructions over valid/ready.
`default_nettype none

module fetch_unit
  import proc_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter int          INST_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_valid;

  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc_load_val;
  logic              w_pc_inc;
  logic              w_capture;
  logic              w_clear_valid;
  logic              w_slot_free;
  logic              w_rom_is_jmp;
  logic [ADDR_W-1:0] w_jmp_target;

  assign w_slot_free  = !r_valid || inst_ready;
  assign w_rom_is_jmp = is_jmp(rom_data[15:0]);
  assign w_jmp_target = ADDR_W'(get_target(rom_data[15:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_load     = 1'b0;
    w_pc_load_val = redirect_pc;
    w_pc_inc      = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Redirect beats everything, including a ready handshake on the held slot.
        if (redirect) begin
          w_pc_load     = 1'b1;
          w_pc_load_val = redirect_pc;
          w_clear_valid = 1'b1;
        end else if (w_slot_free) begin
          if (w_rom_is_jmp) begin
            w_pc_load     = 1'b1;
            w_pc_load_val = w_jmp_target;
            w_clear_valid = 1'b1;
          end else begin
            w_capture = 1'b1;
            w_pc_inc  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_pc_load),
    .i_load_pc (w_pc_load_val),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
    end else if (w_capture) begin
      r_inst    <= rom_data;
      r_inst_pc <= w_pc;
      r_valid   <= 1'b1;
    end else if (w_clear_valid) begin
      r_valid   <= 1'b0;
    end
  end

  assign rom_addr   = w_pc;
  assign inst_out   = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order walker model plus directed cycle checks.
`default_nettype none

module tb_fetch_unit;

  localparam int ADDR_W = 4;
  localparam int INST_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic [INST_W-1:0] rom [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next address that will be presented downstream when fetching from pc,
  // following jmp chains; 16 means a jmp loop that never presents anything.
  function automatic int walk(input int pc_in);
    int pc;
    pc = pc_in;
    for (int i = 0; i < 16; i++) begin
      if (rom[pc][15:12] == 4'h8) pc = int'(rom[pc][11:8]);
      else return pc;
    end
    return 16;
  endfunction

  bit running = 1'b0;
  int exp_next = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else if (!running) begin
      check("idle_valid", int'(inst_valid), 0);
      if (start) begin
        running  <= 1'b1;
        exp_next <= walk(0);
      end
    end else begin
      if (inst_valid) begin
        check("out_matches_rom", int'(inst_out), int'(rom[inst_pc]));
        check("jmp_not_presented", int'(inst_out[15:12] == 4'h8), 0);
      end
      if (redirect) begin
        exp_next <= walk(int'(redirect_pc));
      end else if (inst_valid && inst_ready) begin
        check("stream_order_pc", int'(inst_pc), exp_next);
        exp_next <= walk((int'(inst_pc) + 1) % 16);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [15:0] inst,
                            input logic [3:0] pc, input logic [3:0] ra);
    check({name, "_valid"}, int'(inst_valid), int'(v));
    if (v) begin
      check({name, "_inst"}, int'(inst_out), int'(inst));
      check({name, "_pc"}, int'(inst_pc), int'(pc));
    end
    check({name, "_rom_addr"}, int'(rom_addr), int'(ra));
  endtask

  initial begin
    rom[0]  = 16'h1201; rom[1]  = 16'hB401; rom[2]  = 16'h2222; rom[3]  = 16'h3333;
    rom[4]  = 16'h4444; rom[5]  = 16'h5555; rom[6]  = 16'hFE00; rom[7]  = 16'h8300;
    rom[8]  = 16'hC805; rom[9]  = 16'h9999; rom[10] = 16'hA0A0; rom[11] = 16'hB0B0;
    rom[12] = 16'h8C00; rom[13] = 16'hD0D0; rom[14] = 16'hE0E0; rom[15] = 16'hF0F0;

    rst = 1'b1; start = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;
    check("reset_valid", int'(inst_valid), 0);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_inst_out", int'(inst_out), 0);
    check("reset_inst_pc", int'(inst_pc), 0);
    step(); step();
    rst = 1'b0;
    step();
    expect_out("idle_hold", 1'b0, 16'h0, 4'h0, 4'h0);

    start = 1'b1; inst_ready = 1'b1;
    step();
    start = 1'b0;
    expect_out("run_entry", 1'b0, 16'h0, 4'h0, 4'h0);
    step(); expect_out("first", 1'b1, 16'h1201, 4'h0, 4'h1);
    step(); expect_out("second", 1'b1, 16'hB401, 4'h1, 4'h2);
    step(); expect_out("seq2", 1'b1, 16'h2222, 4'h2, 4'h3);
    step(); expect_out("seq3", 1'b1, 16'h3333, 4'h3, 4'h4);
    step(); expect_out("seq4", 1'b1, 16'h4444, 4'h4, 4'h5);
    step(); expect_out("seq5", 1'b1, 16'h5555, 4'h5, 4'h6);
    step(); expect_out("pre_jmp", 1'b1, 16'hFE00, 4'h6, 4'h7);
    step(); expect_out("jmp_bubble", 1'b0, 16'h0, 4'h0, 4'h3);
    step(); expect_out("jmp_target", 1'b1, 16'h3333, 4'h3, 4'h4);

    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      expect_out("stall_hold", 1'b1, 16'h3333, 4'h3, 4'h4);
    end
    start = 1'b0;
    inst_ready = 1'b1;
    step(); expect_out("stall_release", 1'b1, 16'h4444, 4'h4, 4'h5);

    redirect = 1'b1; redirect_pc = 4'd10;
    step(); expect_out("redirect_bubble", 1'b0, 16'h0, 4'h0, 4'hA);
    redirect = 1'b0;
    step(); expect_out("redirect_target", 1'b1, 16'hA0A0, 4'hA, 4'hB);
    step(); expect_out("after_target", 1'b1, 16'hB0B0, 4'hB, 4'hC);
    for (int i = 0; i < 4; i++) begin
      step(); expect_out("self_jmp_spin", 1'b0, 16'h0, 4'h0, 4'hC);
    end

    redirect = 1'b1; redirect_pc = 4'd14;
    step(); expect_out("redirect14", 1'b0, 16'h0, 4'h0, 4'hE);
    redirect = 1'b0;
    step(); expect_out("pc14", 1'b1, 16'hE0E0, 4'hE, 4'hF);
    step(); expect_out("pc15_wrap", 1'b1, 16'hF0F0, 4'hF, 4'h0);
    step(); expect_out("wrapped", 1'b1, 16'h1201, 4'h0, 4'h1);

    redirect = 1'b1; redirect_pc = 4'd8;
    step(); expect_out("redirect8", 1'b0, 16'h0, 4'h0, 4'h8);
    redirect = 1'b0;
    step(); expect_out("branch_pass", 1'b1, 16'hC805, 4'h8, 4'h9);
    step(); expect_out("after_branch", 1'b1, 16'h9999, 4'h9, 4'hA);

    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(inst_valid), 0);
    check("async_rst_rom_addr", int'(rom_addr), 0);
    check("async_rst_inst_out", int'(inst_out), 0);
    check("async_rst_inst_pc", int'(inst_pc), 0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("no_fetch_after_rst", 1'b0, 16'h0, 4'h0, 4'h0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    expect_out("restart_entry", 1'b0, 16'h0, 4'h0, 4'h0);
    step(); expect_out("restart_first", 1'b1, 16'h1201, 4'h0, 4'h1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
